// File: rtl/pc_updater.sv
// Program Counter stage: issues the PC to Fetch, then waits for the Execute
// result to compute the next PC, trapping on misaligned targets.
package core_pkg;
  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int PC_CTRL_WIDTH = 3;

  localparam logic [PC_CTRL_WIDTH-1:0] PC_INC  = 3'd0;
  localparam logic [PC_CTRL_WIDTH-1:0] PC_SET  = 3'd1;
  localparam logic [PC_CTRL_WIDTH-1:0] PC_ADD  = 3'd2;
  localparam logic [PC_CTRL_WIDTH-1:0] PC_COND = 3'd3;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    exe_out;
    logic [DATA_WIDTH-1:0]    op3;
    logic [PC_CTRL_WIDTH-1:0] pc_ctrl;
  } exe2pc_t;
endpackage

module pc_updater
  import core_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter int                    INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  exe2pc_t                  exe2pc_i,
  input  logic                     exe2pc_valid_i,
  output logic                     exe2pc_ready_o,
  output logic [ADDR_WIDTH-1:0]    pc_o,
  output logic                     pc_valid_o,
  input  logic                     pc_ready_i,
  output logic                     misalign_o,
  output logic [ADDR_WIDTH-1:0]    misalign_addr_o,
  output logic [INSTRET_WIDTH-1:0] instret_o
);
  typedef enum logic [1:0] {ISSUE, WAIT, HALT} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] base, exe_out, op3, seq, target;
  logic                  misalign, xfer;

  // Next-PC datapath; DATA_WIDTH operands are resized to the address width.
  always_comb begin
    base    = exe2pc_i.pc;
    exe_out = ADDR_WIDTH'(exe2pc_i.exe_out);
    op3     = ADDR_WIDTH'(exe2pc_i.op3);
    seq     = base + ADDR_WIDTH'(4);
    target  = seq;
    case (exe2pc_i.pc_ctrl)
      PC_SET:  target = {exe_out[ADDR_WIDTH-1:1], 1'b0};
      PC_ADD:  target = base + exe_out;
      PC_COND: target = exe2pc_i.exe_out[0] ? base + op3 : seq;
      default: target = seq;
    endcase
    misalign = |target[1:0];
  end

  always_comb begin
    state_n        = state;
    pc_valid_o     = 1'b0;
    exe2pc_ready_o = 1'b0;
    xfer           = 1'b0;
    case (state)
      ISSUE: begin
        pc_valid_o = 1'b1;
        if (pc_ready_i) state_n = WAIT;
      end
      WAIT: begin
        exe2pc_ready_o = 1'b1;
        xfer           = exe2pc_valid_i;
        if (exe2pc_valid_i) state_n = misalign ? HALT : ISSUE;
      end
      default: state_n = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= ISSUE;
      pc_o            <= RESET_VECTOR;
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
      instret_o       <= '0;
    end else begin
      state <= state_n;
      if (xfer) begin
        // A misaligned transfer still retires, but leaves the PC untouched.
        instret_o <= instret_o + INSTRET_WIDTH'(1);
        if (misalign) begin
          misalign_o      <= 1'b1;
          misalign_addr_o <= target;
        end else begin
          pc_o <= target;
        end
      end
    end
  end
endmodule

// File: tb/tb_pc_updater.sv
// Self-checking bench for pc_updater: directed vector table, halt/reset
// corner sequences, then randomized traffic against a transaction-level model.
module tb_pc_updater;
  import core_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] RV = 32'h100;
  localparam int                    IW = 4;

  logic                  clk = 1'b0;
  logic                  rstn;
  exe2pc_t               exe2pc;
  logic                  exe2pc_valid, exe2pc_ready;
  logic [ADDR_WIDTH-1:0] pc, misalign_addr;
  logic                  pc_valid, pc_ready, misalign;
  logic [IW-1:0]         instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_updater #(.RESET_VECTOR(RV), .INSTRET_WIDTH(IW)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .exe2pc_i        (exe2pc),
    .exe2pc_valid_i  (exe2pc_valid),
    .exe2pc_ready_o  (exe2pc_ready),
    .pc_o            (pc),
    .pc_valid_o      (pc_valid),
    .pc_ready_i      (pc_ready),
    .misalign_o      (misalign),
    .misalign_addr_o (misalign_addr),
    .instret_o       (instret)
  );

  // Transaction-level model: phase 0 = PC offered, 1 = awaiting EXE, 2 = halted
  int          m_phase;
  logic [31:0] m_pc, m_maddr;
  int          m_cnt;
  logic        m_mis;

  function automatic logic [32:0] next_pc(input exe2pc_t e);
    logic [31:0] t;
    case (e.pc_ctrl)
      PC_SET:  t = e.exe_out & 32'hFFFF_FFFE;
      PC_ADD:  t = e.pc + e.exe_out;
      PC_COND: t = e.exe_out[0] ? e.pc + e.op3 : e.pc + 32'd4;
      default: t = e.pc + 32'd4;
    endcase
    return {(t % 32'd4) != 32'd0, t};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pc = RV; m_cnt = 0; m_mis = 1'b0; m_maddr = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [32:0] r;
    if (m_phase == 0 && pc_ready) m_phase = 1;
    else if (m_phase == 1 && exe2pc_valid) begin
      r     = next_pc(exe2pc);
      m_cnt = (m_cnt + 1) % (1 << IW);
      if (r[32]) begin m_phase = 2; m_mis = 1'b1; m_maddr = r[31:0]; end
      else begin m_phase = 0; m_pc = r[31:0]; end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},        64'(pc),            64'(m_pc));
    check({tag, ".pc_valid"},  64'(pc_valid),      64'(m_phase == 0));
    check({tag, ".ready"},     64'(exe2pc_ready),  64'(m_phase == 1));
    check({tag, ".misalign"},  64'(misalign),      64'(m_mis));
    check({tag, ".mis_addr"},  64'(misalign_addr), 64'(m_maddr));
    check({tag, ".instret"},   64'(instret),       64'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] pc, exe_out, op3;
    logic [2:0]  ctrl;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h100,  32'h0,         32'h0,  PC_INC,  32'h104,  1'b0};
    vecs[1] = '{32'h104,  32'hFFFF_FFF0, 32'h0,  PC_ADD,  32'hF4,   1'b0};
    vecs[2] = '{32'h200,  32'h1,         32'h40, PC_COND, 32'h240,  1'b0};
    vecs[3] = '{32'h200,  32'h0,         32'h40, PC_COND, 32'h204,  1'b0};
    vecs[4] = '{32'h300,  32'h55,        32'h8,  3'd7,    32'h304,  1'b0};
    vecs[5] = '{32'h400,  32'h1235,      32'h0,  PC_SET,  32'h1234, 1'b0};
    vecs[6] = '{32'h500,  32'h1236,      32'h0,  PC_SET,  32'h1234, 1'b1};

    exe2pc = '0; exe2pc_valid = 1'b0; pc_ready = 1'b0; rstn = 1'b0;
    tick(); model_reset(); check_all("reset");
    rstn = 1'b1;

    // Table: handshake PC out (exe2pc_valid noise ignored), then deliver payload.
    for (int i = 0; i < 7; i++) begin
      exe2pc = '{vecs[i].pc, vecs[i].exe_out, vecs[i].op3, vecs[i].ctrl};
      pc_ready = 1'b1; exe2pc_valid = 1'b1;
      model_step(); tick(); check_all($sformatf("v%0d.issue", i));
      model_step(); tick(); check_all($sformatf("v%0d.exe", i));
      check($sformatf("v%0d.tbl_pc", i),  64'(pc),       64'(vecs[i].exp_pc));
      check($sformatf("v%0d.tbl_mis", i), 64'(misalign), 64'(vecs[i].exp_mis));
      check($sformatf("v%0d.tbl_ret", i), 64'(instret),  64'(i + 1));
    end
    check("halt.addr", 64'(misalign_addr), 64'h1236);

    // Halted: every handshake input asserted, nothing may move.
    for (int c = 0; c < 22; c++) begin
      exe2pc.pc_ctrl = PC_INC;
      model_step(); tick(); check_all("halt");
    end

    rstn = 1'b0; tick(); model_reset(); check_all("rst_halt");
    rstn = 1'b1;

    // Fetch backpressure with EXE valid asserted.
    pc_ready = 1'b0; exe2pc_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      model_step(); tick(); check_all("bp");
    end
    pc_ready = 1'b1; model_step(); tick(); check_all("bp_hs");

    // Reset in WAIT with a valid payload present: payload must be dropped.
    exe2pc = '{32'h800, 32'h0, 32'h0, PC_INC};
    rstn = 1'b0; tick(); model_reset(); check_all("rst_wait");
    check("rst_wait.pc_rv", 64'(pc), 64'(RV));
    rstn = 1'b1;

    // Randomized traffic; instret is narrow so it wraps many times.
    for (int n = 0; n < 4000; n++) begin
      logic bad;
      pc_ready     = ($urandom_range(0, 3) != 0);
      exe2pc_valid = ($urandom_range(0, 2) != 0);
      bad          = ($urandom_range(0, 11) == 0);
      exe2pc.pc      = $urandom;
      exe2pc.exe_out = $urandom;
      exe2pc.op3     = $urandom;
      exe2pc.pc_ctrl = 3'($urandom_range(0, 7));
      if (!bad) begin
        exe2pc.pc[1:0]     = 2'b00;
        exe2pc.op3[1:0]    = 2'b00;
        exe2pc.exe_out[1]  = 1'b0;
        if (exe2pc.pc_ctrl == PC_ADD) exe2pc.exe_out[0] = 1'b0;
      end
      rstn = !((m_phase == 2 && $urandom_range(0, 4) == 0) || $urandom_range(0, 299) == 0);
      if (!rstn) model_reset(); else model_step();
      tick(); check_all("rand");
    end
    rstn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_updater.md
Name: pc_updater

Overview:
- Program Counter stage of the SCHOLAR RISC-V core.
- Holds the architectural PC and presents it to Fetch with a valid/ready handshake.
- Consumes the exe2pc_t payload from Execute and computes the next PC from pc_ctrl.
- Single instruction in flight: Fetch → … → EXE → PC.
- Also detects misaligned control-flow targets and counts retired instructions.

Parameters:
- RESET_VECTOR, 'h0000_0000 (ADDR_WIDTH bits): PC value loaded at reset.
- INSTRET_WIDTH, 64: width of the retired-instruction counter.
- ADDR_WIDTH, DATA_WIDTH, PC_CTRL_WIDTH and the pc_ctrl encodings PC_INC/PC_SET/PC_ADD/PC_COND come from core_pkg. They are not parameters.

Ports:
- clk  input  1  core clock; single clock domain.
- rstn  input  1  synchronous, active-low reset.
- exe2pc_i  input  exe2pc_t  {pc, exe_out, op3, pc_ctrl} from EXE.
- exe2pc_valid_i  input  1  exe2pc_i is valid.
- exe2pc_ready_o  output  1  PC stage accepts exe2pc_i.
- pc_o  output  ADDR_WIDTH  PC to Fetch.
- pc_valid_o  output  1  pc_o is valid.
- pc_ready_i  input  1  Fetch accepts pc_o.
- misalign_o  output  1  sticky: misaligned target detected; core halted.
- misalign_addr_o  output  ADDR_WIDTH  offending target address.
- instret_o  output  INSTRET_WIDTH  count of accepted exe2pc transactions.

Behaviour:
- Reset (rstn=0 at a rising clk edge; overrides everything, including mid-transaction):
  - state=ISSUE, pc_o=RESET_VECTOR.
  - misalign_o=0, misalign_addr_o=0, instret_o=0.
  - Any in-flight exe2pc payload is discarded.
- Outputs are decoded from the state:
  - pc_valid_o = (state==ISSUE).
  - exe2pc_ready_o = (state==WAIT).
  - In HALT both are 0.
- ISSUE:
  - pc_valid_o=1; pc_o must stay stable until pc_valid_o & pc_ready_i.
  - On handshake → WAIT at the next edge.
  - exe2pc_valid_i is ignored in ISSUE (ready=0).
- WAIT:
  - exe2pc_ready_o=1. On exe2pc_valid_i=1 the transfer completes that cycle.
  - Next-PC computation, with base = exe2pc_i.pc and arithmetic mod 2^ADDR_WIDTH; DATA_WIDTH operands are truncated/zero-extended to ADDR_WIDTH:
    - PC_INC: base+4.
    - PC_SET: exe_out with bit0 forced to 0 (JALR rule).
    - PC_ADD: base+exe_out.
    - PC_COND: exe_out[0] ? base+op3 : base+4.
    - Any other encoding: treated as PC_INC.
  - Misalignment check: target[1:0]≠0 after the bit0 clear.
    - If misaligned: next state HALT, misalign_o←1, misalign_addr_o←target, pc_o unchanged.
    - Otherwise: pc_o←target, next state ISSUE.
  - instret_o increments on every accepted transfer, including a misaligned one. It wraps to 0 at all-ones.
- Latency: pc_valid_o reasserts exactly 1 cycle after the exe2pc handshake cycle. This gives a minimum loop of ISSUE(1) → WAIT(≥1) → ISSUE.
- HALT: terminal. No handshakes; all outputs hold. Exit only via reset.
- Simultaneous pc_ready_i and exe2pc_valid_i: only the signal relevant to the current state has any effect.
- pc_ready_i held low in ISSUE: remain in ISSUE indefinitely with pc_o stable.

Test Plan:
1. Reset with RESET_VECTOR='h100, then pc_ready_i=1 → pc_o='h100 and pc_valid_o=1 on the first post-reset cycle. Next cycle pc_valid_o=0, exe2pc_ready_o=1.
2. WAIT, exe2pc {pc='h100, PC_INC} valid → next cycle pc_o='h104, pc_valid_o=1, instret_o=1. Repeat with PC_ADD, exe_out='hFFFF_FFF0 → pc_o='hF4 (wrap).
3. PC_COND with pc='h200, op3='h40: exe_out=1 → pc_o='h240; exe_out=0 → pc_o='h204.
4. PC_SET with exe_out='h1235 → pc_o='h1234 is misaligned (bit1=0? no: 'h1234[1:0]=00 → aligned), so pc_o='h1234. Then PC_SET exe_out='h1236 → misalign_o=1, misalign_addr_o='h1236, pc_o holds, both valid/ready stay 0 for 20+ cycles.
5. Backpressure: pc_ready_i=0 for 5 cycles in ISSUE while exe2pc_valid_i=1 → pc_o stable, exe2pc_ready_o=0, instret_o unchanged.
6. Assert rstn=0 during WAIT, and separately during HALT → next cycle state ISSUE, pc_o=RESET_VECTOR, misalign_o=0, instret_o=0.
